// File: rtl/f100l_fetch.sv
// f100l_fetch: F100-L fetch stage; drives rom_address, assembles 1/2-word instructions, presents them via inst_valid/inst_ready, restarts on redirect
module f100l_fetch #(
  parameter int ADDR_WIDTH = 10,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic [ADDR_WIDTH-1:0] rom_address,
  input  logic [15:0]           rom_data,
  input  logic                  redirect,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic [15:0]           inst_word,
  output logic [15:0]           inst_operand,
  output logic                  inst_two_word,
  output logic [ADDR_WIDTH-1:0] inst_pc,
  output logic [ADDR_WIDTH-1:0] next_pc
);
  typedef enum logic [1:0] {FETCH_OP, FETCH_OPERAND, HOLD} state_t;
  state_t state, state_nxt;
  logic [ADDR_WIDTH-1:0] pc, pc_inc;
  logic [3:0] f;
  logic two_word, accept;
  assign f = rom_data[15:12];
  assign two_word = f == 4'd7 || (f == 4'd0 && rom_data[11]) ||
                    (f != 4'd0 && f != 4'd7 && rom_data[10:0] == 11'd0);
  assign pc_inc = pc + ADDR_WIDTH'(1);
  assign rom_address = pc;
  assign inst_valid = state == HOLD;
  assign accept = inst_valid && inst_ready;
  always_ff @(posedge clk)
    if (reset) state <= FETCH_OP;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    state_nxt = redirect                ? FETCH_OP :
                state == FETCH_OP       ? (two_word ? FETCH_OPERAND : HOLD) :
                state == FETCH_OPERAND  ? HOLD :
                accept                  ? FETCH_OP : HOLD;
  end
  always_ff @(posedge clk)
    if (reset) begin
      pc <= RESET_PC;
      inst_word <= '0;
      inst_operand <= '0;
      inst_two_word <= 1'b0;
      inst_pc <= '0;
      next_pc <= '0;
    end else if (redirect) begin
      pc <= redirect_pc;
    end else if (state == FETCH_OP) begin
      inst_word <= rom_data;
      inst_operand <= '0;
      inst_two_word <= two_word;
      inst_pc <= pc;
      pc <= pc_inc;
      next_pc <= pc_inc;
    end else if (state == FETCH_OPERAND) begin
      inst_operand <= rom_data;
      pc <= pc_inc;
      next_pc <= pc_inc;
    end
endmodule

// File: tb/tb_f100l_fetch.sv
// tb_f100l_fetch: randomized and directed checks of f100l_fetch against a cycle-level instruction model
module tb_f100l_fetch;
  logic clk = 1'b0, reset = 1'b1;
  logic [9:0] rom_address, redirect_pc = '0, inst_pc, next_pc;
  logic [15:0] rom_data, inst_word, inst_operand;
  logic redirect = 1'b0, inst_valid, inst_ready = 1'b0, inst_two_word;
  logic [15:0] rom [1024];
  int n_chk = 0, n_pass = 0, cyc = 0, s = 0;
  logic [9:0] a = '0;

  f100l_fetch #(.ADDR_WIDTH(10), .RESET_PC(10'd0)) dut (
    .clk(clk), .reset(reset), .rom_address(rom_address), .rom_data(rom_data),
    .redirect(redirect), .redirect_pc(redirect_pc), .inst_valid(inst_valid),
    .inst_ready(inst_ready), .inst_word(inst_word), .inst_operand(inst_operand),
    .inst_two_word(inst_two_word), .inst_pc(inst_pc), .next_pc(next_pc)
  );

  assign rom_data = rom[rom_address];
  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  function automatic int ilen(logic [15:0] w);
    int op;
    op = int'(w[15:12]);
    if (op == 7) return 2;
    if (op == 0) return w[11] ? 2 : 1;
    return (w[10:0] == 11'd0) ? 2 : 1;
  endfunction

  task automatic clear_rom();
    for (int i = 0; i < 1024; i++) rom[i] = 16'h0000;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    inst_ready = 1'b0;
    redirect = 1'b0;
    redirect_pc = '0;
    @(negedge clk);
    chk("rst_valid", 32'(inst_valid), 0);
    chk("rst_rom_address", 32'(rom_address), 0);
    chk("rst_word", 32'(inst_word), 0);
    chk("rst_operand", 32'(inst_operand), 0);
    chk("rst_two_word", 32'(inst_two_word), 0);
    chk("rst_inst_pc", 32'(inst_pc), 0);
    chk("rst_next_pc", 32'(next_pc), 0);
    reset = 1'b0;
    cyc = 0;
    s = 0;
    a = 10'd0;
  endtask

  // s = cycle in which fetch of the instruction at a began; it is presented from s+len until taken
  task automatic step(bit r, bit d, logic [9:0] p);
    int len, el;
    bit ev;
    logic [9:0] ea;
    len = ilen(rom[a]);
    ev = cyc >= s + len;
    el = (cyc - s > len) ? len : cyc - s;
    ea = a + 10'(el);
    chk("valid", 32'(inst_valid), 32'(ev));
    chk("rom_address", 32'(rom_address), 32'(ea));
    if (ev) begin
      ea = a + 10'd1;
      chk("word", 32'(inst_word), 32'(rom[a]));
      chk("operand", 32'(inst_operand), len == 2 ? 32'(rom[ea]) : 0);
      chk("two_word", 32'(inst_two_word), 32'(len == 2));
      chk("inst_pc", 32'(inst_pc), 32'(a));
      ea = a + 10'(len);
      chk("next_pc", 32'(next_pc), 32'(ea));
    end
    inst_ready = r;
    redirect = d;
    redirect_pc = p;
    if (d) begin
      s = cyc + 1;
      a = p;
    end else if (ev && r) begin
      s = cyc + 1;
      a = a + 10'(len);
    end
    cyc++;
    @(negedge clk);
  endtask

  function automatic logic [15:0] rand_word();
    logic [15:0] w;
    w = 16'($urandom);
    case ($urandom_range(0, 3))
      1: w[10:0] = 11'd0;
      2: w[15:12] = 4'd7;
      3: w[15:11] = 5'b00001;
      default: ;
    endcase
    return w;
  endfunction

  initial begin
    clear_rom();
    rom[0] = 16'h8000; rom[1] = 16'hfffd; rom[2] = 16'h4005;
    do_reset();
    repeat (6) step(1, 0, 0);
    do_reset();
    step(1, 0, 0); step(1, 0, 0);
    repeat (5) step(0, 0, 0);
    repeat (5) step(1, 0, 0);
    clear_rom();
    rom[6] = 16'h7005; rom[7] = 16'h2005; rom[8] = 16'h0400;
    do_reset();
    step(1, 1, 10'd6);
    repeat (8) step(1, 0, 0);
    clear_rom();
    rom[0] = 16'h8000; rom[1] = 16'hfffd; rom[3] = 16'h8000; rom[4] = 16'h8000;
    do_reset();
    step(1, 0, 0);
    step(1, 1, 10'd3);
    repeat (5) step(1, 0, 0);
    clear_rom();
    rom[1023] = 16'h8000; rom[0] = 16'h1234;
    do_reset();
    step(1, 1, 10'd1023);
    repeat (6) step(1, 0, 0);
    clear_rom();
    rom[0] = 16'h8000; rom[1] = 16'hfffd; rom[2] = 16'h4005;
    do_reset();
    step(1, 0, 0);
    do_reset();
    repeat (6) step(1, 0, 0);
    clear_rom();
    rom[0] = 16'h4005; rom[8] = 16'h0072;
    do_reset();
    step(1, 0, 0);
    step(1, 1, 10'd8);
    repeat (4) step(1, 0, 0);
    for (int i = 0; i < 1024; i++) rom[i] = rand_word();
    do_reset();
    repeat (4000) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      else step($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, 10'($urandom));
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/f100l_fetch.md
# f100l_fetch

Instruction fetch stage for the F100-L soft processor, sitting directly downstream of the program ROM. It drives the ROM word address, collects one- or two-word F100-L instructions, and presents each complete instruction to the decoder over a valid/ready handshake. Jump, call, and return redirects from the execute stage restart fetch at a new address.

## Interface
Parameters:
- ADDR_WIDTH, 10: ROM word-address width.
- RESET_PC, 0: fetch address after reset.

Ports:
- clk, input, 1: single clock, rising edge.
- reset, input, 1: synchronous, active-high.
- rom_address, output, ADDR_WIDTH: word address to the ROM. Equals the internal pc.
- rom_data, input, 16: ROM word, combinational from rom_address.
- redirect, input, 1: load a new fetch address.
- redirect_pc, input, ADDR_WIDTH: new fetch address.
- inst_valid, output, 1: complete instruction available.
- inst_ready, input, 1: decoder accepts the instruction.
- inst_word, output, 16: first (opcode) word.
- inst_operand, output, 16: second word; 0 for one-word instructions.
- inst_two_word, output, 1: instruction occupied two ROM words.
- inst_pc, output, ADDR_WIDTH: address of inst_word.
- next_pc, output, ADDR_WIDTH: address following the instruction (return address for CAL).

## Operation
- Length decode of the first word: F = [15:12], N = [10:0].
  - Two-word if F == 7 (ICZ, second word is the jump target).
  - Two-word if F == 0 and bit 11 == 1 (bit-test jumps).
  - Two-word if F is not 0 and not 7 and N == 0 (immediate or long-address form, e.g. 0x8000).
  - Everything else is one word (0x4005, 0x0072, 0x0400).
- States:
  - FETCH_OP: latch rom_data into inst_word and inst_pc <= pc, then pc <= pc+1. Go to FETCH_OPERAND if two-word, else HOLD.
  - FETCH_OPERAND: latch rom_data into inst_operand, then pc <= pc+1. Go to HOLD.
  - HOLD: inst_valid = 1. On inst_valid && inst_ready, go to FETCH_OP.
- Outputs are stable while inst_valid is high and inst_ready is low.
- next_pc equals pc while in HOLD.
- pc arithmetic is modulo 2^ADDR_WIDTH: 1023+1 = 0. A two-word instruction at 1023 takes its operand from 0.
- Redirect has priority over every state. It sets pc <= redirect_pc, inst_valid <= 0, state <= FETCH_OP, and discards any partially fetched instruction.
- Redirect together with an accept in the same cycle: the accept completes, and fetch restarts at redirect_pc.
- HALT (0x0400) gets no special handling; the execute stage stops accepting.

## Timing
- Reset: pc = RESET_PC, state = FETCH_OP, inst_valid = 0, and inst_word, inst_operand, inst_two_word, inst_pc, next_pc all 0.
- Cycle numbering: cycle 0 is the first cycle with reset low.
- One-word instruction: inst_valid high in cycle 1.
- Two-word instruction: inst_valid high in cycle 2.
- Accept in cycle k (valid && ready at the edge ending cycle k): inst_valid is low in cycle k+1. The next instruction is valid in cycle k+2 (one word) or k+3 (two words).
- Best-case throughput: one instruction per 2 cycles (one-word) or 3 cycles (two-word).
- Redirect asserted in cycle k: rom_address = redirect_pc in cycle k+1. First instruction from the new address is valid in cycle k+2 or k+3.
- No combinational path from inst_ready or redirect to any output.

## Test plan
- ROM 0:0x8000, 1:0xfffd, 2:0x4005, inst_ready held 1 -> cycle 2 shows inst_word=0x8000, inst_operand=0xfffd, two_word=1, inst_pc=0, next_pc=2. Cycle 4 shows inst_word=0x4005, operand=0, two_word=0, inst_pc=2, next_pc=3.
- Backpressure: inst_ready=0 for 5 cycles while the 0x8000/0xfffd instruction is valid -> outputs unchanged and rom_address held at 2. Setting inst_ready=1 -> accepted once, never duplicated.
- ICZ 0x7005, 0x2005 at addresses 6-7 -> two_word=1, operand=0x2005, next_pc=8. Then 0x0400 at 8 -> one word.
- Redirect to 0x003 during FETCH_OPERAND of the instruction at 0 -> no instruction from address 0 is presented. Next valid is inst_word=0x8000, operand=0x8000, inst_pc=3.
- Wrap-around: redirect to 1023 with 0x8000 at 1023 and 0x1234 at 0 -> operand=0x1234, inst_pc=1023, next_pc=1.
- Reset asserted mid-FETCH_OPERAND -> next cycle inst_valid=0 and rom_address=RESET_PC. First instruction after release is the one at RESET_PC.
